// File: rtl/riscv_decode_pipe_ctrl.sv
// RV32I decode controller: D-stage decode, D/E control register,
// illegal-op drain/halt FSM and saturating decoded-instruction counter.
module riscv_decode_pipe_ctrl #(
  parameter int DRAIN_CYCLES       = 3,
  parameter int ENABLE_SHIFT       = 1,
  parameter int ENABLE_UNSIGNED_BR = 1,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      InstrD,
  input  logic             ValidD,
  input  logic             StallE,
  input  logic             FlushE,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             JumpSelE,
  output logic             BranchE,
  output logic [2:0]       BrCondE,
  output logic [3:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [2:0]       ImmSrcE,
  output logic             done,
  output logic [CNT_W-1:0] DecodedCnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] A_ADD  = 4'b0000;
  localparam logic [3:0] A_SUB  = 4'b0001;
  localparam logic [3:0] A_AND  = 4'b0010;
  localparam logic [3:0] A_OR   = 4'b0011;
  localparam logic [3:0] A_PASS = 4'b0100;
  localparam logic [3:0] A_SLT  = 4'b0101;
  localparam logic [3:0] A_SLTU = 4'b0110;
  localparam logic [3:0] A_XOR  = 4'b0111;
  localparam logic [3:0] A_SLL  = 4'b1000;
  localparam logic [3:0] A_SRL  = 4'b1001;
  localparam logic [3:0] A_SRA  = 4'b1010;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       jump_sel;
    logic       branch;
    logic [2:0] br_cond;
    logic [3:0] alu_ctl;
    logic       alu_src;
    logic [2:0] imm_src;
  } ctl_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    dcnt, dcnt_n;
  logic             done_n;
  ctl_t             dec, e_q, e_n;
  logic             v_q, v_n;
  logic             known, bad, illegal, inc;
  logic [3:0]       alu_ri;
  logic [CNT_W-1:0] cnt_n;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       alt, is_r, is_shift;
  logic       unused;

  assign op       = InstrD[6:0];
  assign f3       = InstrD[14:12];
  assign f7       = InstrD[31:25];
  assign alt      = (f7 == 7'b0100000);
  assign is_r     = (op == OP_R);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign unused   = ^{InstrD[24:15], InstrD[11:7]};

  // ALU operation for register and immediate arithmetic
  always_comb begin
    alu_ri = A_ADD;
    unique case (f3)
      3'b000:  alu_ri = (is_r && alt) ? A_SUB : A_ADD;
      3'b001:  alu_ri = A_SLL;
      3'b010:  alu_ri = A_SLT;
      3'b011:  alu_ri = A_SLTU;
      3'b100:  alu_ri = A_XOR;
      3'b101:  alu_ri = alt ? A_SRA : A_SRL;
      3'b110:  alu_ri = A_OR;
      default: alu_ri = A_AND;
    endcase
  end

  // opcode decode into the control bundle plus legality
  always_comb begin
    dec   = '0;
    known = 1'b1;
    bad   = 1'b0;
    unique case (op)
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
      end
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctl   = alu_ri;
        bad = is_shift && (ENABLE_SHIFT == 0);
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_ctl   = alu_ri;
        dec.alu_src   = 1'b1;
        bad = is_shift && (ENABLE_SHIFT == 0);
      end
      OP_B: begin
        dec.branch  = 1'b1;
        dec.br_cond = f3;
        dec.alu_ctl = A_SUB;
        dec.imm_src = 3'b010;
        bad = (f3[2:1] == 2'b01) ||
              ((f3[2:1] == 2'b11) && (ENABLE_UNSIGNED_BR == 0));
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        dec.jump_sel   = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        dec.imm_src    = 3'b011;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_ctl   = A_PASS;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b100;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
        dec.alu_src    = 1'b1;
        dec.imm_src    = 3'b100;
      end
      default: known = 1'b0;
    endcase
    illegal = ValidD && (!known || bad);
  end

  // halt FSM next state and D/E register next value
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    done_n  = done;
    e_n     = e_q;
    v_n     = v_q;
    inc     = 1'b0;
    unique case (state)
      RUN: begin
        if (!StallE) begin
          e_n = '0;
          v_n = 1'b0;
          if (!FlushE) begin
            if (illegal) begin
              state_n = DRAIN;
              dcnt_n  = DW'(DRAIN_CYCLES - 1);
            end else if (ValidD) begin
              e_n = dec;
              v_n = 1'b1;
              inc = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (!StallE) begin
          e_n = '0;
          v_n = 1'b0;
          if (dcnt == '0) begin
            state_n = HALTED;
            done_n  = 1'b1;
          end else begin
            dcnt_n = dcnt - DW'(1);
          end
        end
      end
      default: begin
        if (!StallE) begin
          e_n = '0;
          v_n = 1'b0;
        end
      end
    endcase
    cnt_n = DecodedCnt;
    if (inc && (DecodedCnt != '1)) begin
      cnt_n = DecodedCnt + CNT_W'(1);
    end
  end

  // state, D/E register, done flag and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      dcnt       <= '0;
      done       <= 1'b0;
      e_q        <= '0;
      v_q        <= 1'b0;
      DecodedCnt <= '0;
    end else begin
      state      <= state_n;
      dcnt       <= dcnt_n;
      done       <= done_n;
      e_q        <= e_n;
      v_q        <= v_n;
      DecodedCnt <= cnt_n;
    end
  end

  assign ValidE      = v_q;
  assign RegWriteE   = e_q.reg_write;
  assign ResultSrcE  = e_q.result_src;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign JumpSelE    = e_q.jump_sel;
  assign BranchE     = e_q.branch;
  assign BrCondE     = e_q.br_cond;
  assign ALUControlE = e_q.alu_ctl;
  assign ALUSrcE     = e_q.alu_src;
  assign ImmSrcE     = e_q.imm_src;

endmodule

// File: tb/tb_riscv_decode_pipe_ctrl.sv
// Bench for riscv_decode_pipe_ctrl: directed steps plus random
// stimulus against a behavioural reference of the decode/halt rules.
module tb_riscv_decode_pipe_ctrl;

  localparam int DC    = 3;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   InstrD = '0;
  logic          ValidD = 1'b0;
  logic          StallE = 1'b0;
  logic          FlushE = 1'b0;
  logic          ValidE, RegWriteE, MemWriteE, JumpE, JumpSelE;
  logic          BranchE, ALUSrcE, done;
  logic [1:0]    ResultSrcE;
  logic [2:0]    BrCondE, ImmSrcE;
  logic [3:0]    ALUControlE;
  logic [CW-1:0] DecodedCnt;

  always #5 clk = ~clk;

  riscv_decode_pipe_ctrl #(
    .DRAIN_CYCLES(DC),
    .ENABLE_SHIFT(1),
    .ENABLE_UNSIGNED_BR(1),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .JumpSelE(JumpSelE),
    .BranchE(BranchE), .BrCondE(BrCondE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .ImmSrcE(ImmSrcE), .done(done),
    .DecodedCnt(DecodedCnt)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [18:0] obs;
  assign obs = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE,
                JumpSelE, BranchE, BrCondE, ALUControlE, ALUSrcE,
                ImmSrcE};

  logic [18:0] e_exp;
  int          cnt_exp;
  int          mode;
  int          rem;
  logic        done_exp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] ins,
                                  output logic legal,
                                  output logic [17:0] c);
    logic [3:0] tab [8];
    logic       rw, mw, j, js, br, as;
    logic [1:0] rs;
    logic [2:0] bc, is, f3;
    logic [3:0] alu;
    logic [6:0] f7;
    tab = '{4'd0, 4'd8, 4'd5, 4'd6, 4'd7, 4'd9, 4'd3, 4'd2};
    f3 = ins[14:12];
    f7 = ins[31:25];
    rw = 0; mw = 0; j = 0; js = 0; br = 0; as = 0;
    rs = 0; bc = 0; is = 0; alu = 0;
    legal = 1'b1;
    case (ins[6:0])
      7'b0000011: begin rw = 1; rs = 2'd1; as = 1; end
      7'b0100011: begin mw = 1; as = 1; is = 3'd1; end
      7'b0110011: begin
        rw = 1;
        alu = tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) alu = 4'd1;
        if (f7 == 7'h20 && f3 == 3'd5) alu = 4'd10;
      end
      7'b0010011: begin
        rw = 1; as = 1;
        alu = tab[f3];
        if (f7 == 7'h20 && f3 == 3'd5) alu = 4'd10;
      end
      7'b1100011: begin
        br = 1; bc = f3; is = 3'd2; alu = 4'd1;
        legal = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'b1100111: begin rw = 1; rs = 2'd2; j = 1; js = 1; as = 1; end
      7'b1101111: begin rw = 1; rs = 2'd2; j = 1; is = 3'd3; end
      7'b0110111: begin rw = 1; as = 1; is = 3'd4; alu = 4'd4; end
      7'b0010111: begin rw = 1; rs = 2'd3; as = 1; is = 3'd4; end
      default: legal = 1'b0;
    endcase
    c = {rw, rs, mw, j, js, br, bc, alu, as, is};
  endfunction

  task automatic mdl();
    logic        lg;
    logic [17:0] c;
    ref_dec(InstrD, lg, c);
    if (rst) begin
      e_exp = '0; cnt_exp = 0; mode = 0; rem = 0; done_exp = 0;
    end else if (!StallE) begin
      if (mode == 0) begin
        if (FlushE) e_exp = '0;
        else if (ValidD && !lg) begin
          e_exp = '0; mode = 1; rem = DC;
        end else if (ValidD) begin
          e_exp = {1'b1, c};
          if (cnt_exp < CMAX) cnt_exp++;
        end else e_exp = '0;
      end else if (mode == 1) begin
        e_exp = '0;
        rem--;
        if (rem == 0) begin mode = 2; done_exp = 1; end
      end else e_exp = '0;
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic v,
                      input logic s, input logic f, input logic r);
    InstrD = ins; ValidD = v; StallE = s; FlushE = f; rst = r;
    @(posedge clk);
    mdl();
    #1;
    chk("bundle", 32'(obs), 32'(e_exp));
    chk("cnt", 32'(DecodedCnt), 32'(cnt_exp));
    chk("done", 32'(done), 32'(done_exp));
  endtask

  function automatic logic [31:0] rnd_legal();
    logic [31:0] w;
    logic [2:0]  bf [6];
    int          k;
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    w = $urandom;
    k = $urandom_range(0, 8);
    case (k)
      0: w[6:0] = 7'b0000011;
      1: w[6:0] = 7'b0100011;
      2: begin
        w[6:0] = 7'b0110011;
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      3: begin
        w[6:0] = 7'b0010011;
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      4: begin
        w[6:0] = 7'b1100011;
        w[14:12] = bf[$urandom_range(0, 5)];
      end
      5: w[6:0] = 7'b1100111;
      6: w[6:0] = 7'b1101111;
      7: w[6:0] = 7'b0110111;
      default: w[6:0] = 7'b0010111;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] SRAI  = 32'h4030D093;
  localparam logic [31:0] BLTU  = 32'h0020E063;
  localparam logic [31:0] LW    = 32'h0040A103;
  localparam logic [31:0] SW    = 32'h0020A223;
  localparam logic [31:0] AUIPC = 32'h00001097;
  localparam logic [31:0] BAD   = 32'h00000000;

  initial begin
    int c0;
    logic [31:0] ins;
    step(BAD, 0, 0, 0, 1);
    step(BAD, 0, 0, 0, 1);
    chk("rst_valid", 32'(ValidE), 0);
    chk("rst_cnt", 32'(DecodedCnt), 0);
    chk("rst_done", 32'(done), 0);

    step(ADD, 1, 0, 0, 0);
    chk("add_rw", 32'(RegWriteE), 1);
    chk("add_alu", 32'(ALUControlE), 0);
    chk("add_valid", 32'(ValidE), 1);
    chk("add_cnt", 32'(DecodedCnt), 1);

    step(SRAI, 1, 0, 0, 0);
    chk("srai_alu", 32'(ALUControlE), 32'hA);
    chk("srai_src", 32'(ALUSrcE), 1);
    step(BLTU, 1, 0, 0, 0);
    chk("bltu_br", 32'(BranchE), 1);
    chk("bltu_cond", 32'(BrCondE), 3'b110);
    chk("bltu_imm", 32'(ImmSrcE), 3'b010);
    chk("bltu_alu", 32'(ALUControlE), 1);

    step(LW, 1, 0, 0, 0);
    step(SW, 1, 1, 0, 0);
    chk("stall1_mw", 32'(MemWriteE), 0);
    chk("stall1_rs", 32'(ResultSrcE), 1);
    step(SW, 1, 1, 0, 0);
    chk("stall2_mw", 32'(MemWriteE), 0);
    step(SW, 1, 0, 0, 0);
    chk("sw_mw", 32'(MemWriteE), 1);

    c0 = int'(DecodedCnt);
    step(AUIPC, 1, 0, 1, 0);
    chk("flush_valid", 32'(ValidE), 0);
    chk("flush_ctl", 32'(obs), 0);
    chk("flush_cnt", 32'(DecodedCnt), 32'(c0));
    step(AUIPC, 1, 0, 0, 0);
    chk("auipc_rs", 32'(ResultSrcE), 3);

    step(BAD, 1, 0, 1, 0);
    step(ADD, 1, 0, 0, 0);
    chk("wrongpath_done", 32'(done), 0);
    chk("wrongpath_valid", 32'(ValidE), 1);

    step(BAD, 1, 1, 0, 0);
    step(BAD, 1, 1, 0, 0);
    step(BAD, 1, 0, 0, 0);
    chk("acc_valid", 32'(ValidE), 0);
    step(ADD, 1, 0, 0, 0);
    chk("drain1_valid", 32'(ValidE), 0);
    chk("drain1_done", 32'(done), 0);
    step(ADD, 1, 0, 0, 0);
    chk("drain2_done", 32'(done), 0);
    step(ADD, 1, 1, 0, 0);
    chk("drain_stall_done", 32'(done), 0);
    step(ADD, 1, 0, 1, 0);
    chk("halt_done", 32'(done), 1);
    for (int i = 0; i < 4; i++) step(ADD, 1, 0, 0, 0);
    chk("halt_sticky", 32'(done), 1);
    chk("halt_valid", 32'(ValidE), 0);
    step(ADD, 1, 0, 0, 1);
    chk("rst_clears_done", 32'(done), 0);

    for (int i = 0; i < 800; i++) begin
      ins = ($urandom_range(0, 99) < 3) ? 32'($urandom) : rnd_legal();
      step(ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
    end

    step(BAD, 0, 0, 0, 1);
    for (int i = 0; i < CMAX; i++) step(rnd_legal(), 1, 0, 0, 0);
    chk("sat_full", 32'(DecodedCnt), 255);
    step(ADD, 1, 0, 0, 0);
    chk("sat_hold", 32'(DecodedCnt), 255);
    step(LW, 1, 0, 0, 0);
    chk("sat_hold2", 32'(DecodedCnt), 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
